// File: rtl/add_rs_pkg.sv
// Shared types for the add/sub/branch reservation station: ROB tags, op encoding,
// source operand and entry payload records, plus small helpers used by the top.
package add_rs_pkg;

  localparam int ROB_BITS = 3;
  localparam int DATA_W   = 32;

  typedef logic [ROB_BITS-1:0] rob_t;

  typedef struct packed {
    logic sub;
    logic bne;
    logic beq;
    logic blt;
  } alu_op_t;

  typedef struct packed {
    logic              rdy;
    rob_t              tag;
    logic [DATA_W-1:0] val;
  } rs_src_t;

  // Entry payload; the per-entry valid bit lives in its own reset register.
  typedef struct packed {
    rob_t    rob;
    alu_op_t op;
    rs_src_t s1;
    rs_src_t s2;
  } rs_entry_t;

  // Distance from the ROB head, wrapping modulo the ROB size.
  function automatic rob_t rob_age(rob_t rob, rob_t head);
    return rob - head;
  endfunction

  // A waiting operand grabs the CDB value when its producer tag is broadcast.
  function automatic rs_src_t src_capture(rs_src_t s, logic cdb_v, rob_t cdb_rob,
                                          logic [DATA_W-1:0] cdb_val);
    rs_src_t r;
    r = s;
    if (!s.rdy && cdb_v && (s.tag == cdb_rob)) begin
      r.rdy = 1'b1;
      r.val = cdb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_rs_if.sv
// Dispatch, CDB and issue bundle of the add reservation station.
// The slave modport is the station; master is the dispatch/CDB/adder side.
interface add_rs_if;
  import add_rs_pkg::*;

  logic              disp_valid;
  logic              disp_ready;
  rob_t              disp_rob;
  alu_op_t           disp_op;
  logic              disp_s1_rdy;
  rob_t              disp_s1_tag;
  logic [DATA_W-1:0] disp_s1_val;
  logic              disp_s2_rdy;
  rob_t              disp_s2_tag;
  logic [DATA_W-1:0] disp_s2_val;

  logic              cdb_valid;
  rob_t              cdb_rob;
  logic [DATA_W-1:0] cdb_value;

  logic              issue_valid;
  logic              issue_ready;
  rob_t              issue_rob;
  alu_op_t           issue_op;
  logic [DATA_W-1:0] issue_rs1;
  logic [DATA_W-1:0] issue_rs2;

  modport slave (
    input  disp_valid, disp_rob, disp_op,
    input  disp_s1_rdy, disp_s1_tag, disp_s1_val,
    input  disp_s2_rdy, disp_s2_tag, disp_s2_val,
    input  cdb_valid, cdb_rob, cdb_value,
    input  issue_ready,
    output disp_ready,
    output issue_valid, issue_rob, issue_op, issue_rs1, issue_rs2
  );

  modport master (
    output disp_valid, disp_rob, disp_op,
    output disp_s1_rdy, disp_s1_tag, disp_s1_val,
    output disp_s2_rdy, disp_s2_tag, disp_s2_val,
    output cdb_valid, cdb_rob, cdb_value,
    output issue_ready,
    input  disp_ready,
    input  issue_valid, issue_rob, issue_op, issue_rs1, issue_rs2
  );

endinterface

// File: rtl/add_rs_age_picker.sv
// Oldest-first selector: among eligible entries, grant the one with the smallest age.
// Ages are unique for valid entries, so strict less-than needs no tie-break.
module add_rs_age_picker #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 3
) (
  input  logic [DEPTH-1:0]         elig_i,
  input  logic [AGE_W-1:0]         age_i [DEPTH],
  output logic [DEPTH-1:0]         grant_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     any_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             found;
  logic [AGE_W-1:0] best;

  always_comb begin
    found   = 1'b0;
    best    = '1;
    idx_o   = '0;
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_i[i] && (!found || (age_i[i] < best))) begin
        found = 1'b1;
        best  = age_i[i];
        idx_o = IDX_W'(i);
      end
    end
    grant_o[idx_o] = found;
    any_o          = found;
  end

endmodule

// File: rtl/add_rs.sv
// Reservation station for the add/sub/branch unit: holds dispatched ops, wakes operands
// from the CDB and presents the oldest fully ready entry to the adder.
module add_rs
  import add_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  rob_t     rob_head,
  add_rs_if.slave  rs
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] grant;
  rob_t             age [DEPTH];
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire;
  logic             issue_fire;

  // Selection sees registered operands only, so a same-cycle wakeup cannot issue yet.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
      age[i]  = rob_age(ent_q[i].rob, rob_head);
    end
  end

  add_rs_age_picker #(
    .DEPTH (DEPTH),
    .AGE_W (ROB_BITS)
  ) u_picker (
    .elig_i  (elig),
    .age_i   (age),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign rs.issue_valid = pick_any;
  assign rs.issue_rob   = ent_q[pick_idx].rob;
  assign rs.issue_op    = ent_q[pick_idx].op;
  assign rs.issue_rs1   = ent_q[pick_idx].s1.val;
  assign rs.issue_rs2   = ent_q[pick_idx].s2.val;

  assign rs.disp_ready  = ~&valid_q;
  assign disp_fire      = rs.disp_valid & rs.disp_ready;
  assign issue_fire     = pick_any & rs.issue_ready;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    valid_d = valid_q & ~(issue_fire ? grant : '0);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (valid_q[i]) begin
        ent_d[i].s1 = src_capture(ent_q[i].s1, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
        ent_d[i].s2 = src_capture(ent_q[i].s2, rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
      end
    end
    if (disp_fire) begin
      valid_d[free_idx]     = 1'b1;
      ent_d[free_idx].rob   = rs.disp_rob;
      ent_d[free_idx].op    = rs.disp_op;
      ent_d[free_idx].s1    = src_capture(
        rs_src_t'{rdy: rs.disp_s1_rdy, tag: rs.disp_s1_tag, val: rs.disp_s1_val},
        rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
      ent_d[free_idx].s2    = src_capture(
        rs_src_t'{rdy: rs.disp_s2_rdy, tag: rs.disp_s2_tag, val: rs.disp_s2_val},
        rs.cdb_valid, rs.cdb_rob, rs.cdb_value);
    end
  end

  // Flush and reset both win over same-cycle dispatch and issue.
  always_ff @(posedge clk) begin
    if (reset || flush) valid_q <= '0;
    else                valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_add_rs.sv
// Directed bench for add_rs: a per-cycle vector table for the basic flows plus
// hand-written sequences for full, flush and mid-operation reset behaviour.
module tb_add_rs;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] rob_head;

  add_rs_if bus();

  add_rs #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rob_head (rob_head),
    .rs       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fl;
    logic [2:0]  head;
    logic        dv;
    logic [2:0]  drob;
    logic [3:0]  dop;
    logic        s1r;
    logic [2:0]  s1t;
    logic [31:0] s1v;
    logic        s2r;
    logic [2:0]  s2t;
    logic [31:0] s2v;
    logic        cv;
    logic [2:0]  crob;
    logic [31:0] cval;
    logic        ir;
    logic        e_dr;
    logic        e_iv;
    logic [2:0]  e_rob;
    logic [3:0]  e_op;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
  } vec_t;

  localparam logic T = 1'b1;
  localparam int NV = 16;

  int   checks = 0;
  int   errors = 0;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush           = 1'b0;
    rob_head        = 3'd0;
    bus.disp_valid  = 1'b0;
    bus.disp_rob    = 3'd0;
    bus.disp_op     = 4'b0000;
    bus.disp_s1_rdy = 1'b0;
    bus.disp_s1_tag = 3'd0;
    bus.disp_s1_val = 32'd0;
    bus.disp_s2_rdy = 1'b0;
    bus.disp_s2_tag = 3'd0;
    bus.disp_s2_val = 32'd0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_rob     = 3'd0;
    bus.cdb_value   = 32'd0;
    bus.issue_ready = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    flush           = v.fl;
    rob_head        = v.head;
    bus.disp_valid  = v.dv;
    bus.disp_rob    = v.drob;
    bus.disp_op     = v.dop;
    bus.disp_s1_rdy = v.s1r;
    bus.disp_s1_tag = v.s1t;
    bus.disp_s1_val = v.s1v;
    bus.disp_s2_rdy = v.s2r;
    bus.disp_s2_tag = v.s2t;
    bus.disp_s2_val = v.s2v;
    bus.cdb_valid   = v.cv;
    bus.cdb_rob     = v.crob;
    bus.cdb_value   = v.cval;
    bus.issue_ready = v.ir;
  endtask

  task automatic disp(input logic [2:0] rob, input logic [3:0] op,
                      input logic s1r, input logic [2:0] s1t, input logic [31:0] s1v,
                      input logic s2r, input logic [2:0] s2t, input logic [31:0] s2v);
    bus.disp_valid  = 1'b1;
    bus.disp_rob    = rob;
    bus.disp_op     = op;
    bus.disp_s1_rdy = s1r;
    bus.disp_s1_tag = s1t;
    bus.disp_s1_val = s1v;
    bus.disp_s2_rdy = s2r;
    bus.disp_s2_tag = s2t;
    bus.disp_s2_val = s2v;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk_issue(input string tag, input logic [2:0] rob,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    chk({tag, "_iv"},  32'(bus.issue_valid), 32'd1);
    chk({tag, "_rob"}, 32'(bus.issue_rob),   32'(rob));
    chk({tag, "_rs1"}, bus.issue_rs1,        rs1);
    chk({tag, "_rs2"}, bus.issue_rs2,        rs2);
  endtask

  initial begin
    // Test 1: single ready op; Test 2: late CDB wakeup; Test 3: wakeup during dispatch;
    // Test 4: age wraps around rob_head=6.
    tv[0]  = '{dv:T, drob:3'd2, dop:4'b1000, s1r:T, s1v:32'd10, s2r:T, s2v:32'd3, ir:T, e_dr:T, default:'0};
    tv[1]  = '{ir:T, e_dr:T, e_iv:T, e_rob:3'd2, e_op:4'b1000, e_rs1:32'd10, e_rs2:32'd3, default:'0};
    tv[2]  = '{ir:T, e_dr:T, default:'0};
    tv[3]  = '{dv:T, drob:3'd4, dop:4'b0100, s1r:T, s1v:32'd1, s2t:3'd3, ir:T, e_dr:T, default:'0};
    tv[4]  = '{ir:T, e_dr:T, default:'0};
    tv[5]  = '{cv:T, crob:3'd3, cval:32'h55, ir:T, e_dr:T, default:'0};
    tv[6]  = '{ir:T, e_dr:T, e_iv:T, e_rob:3'd4, e_op:4'b0100, e_rs1:32'd1, e_rs2:32'h55, default:'0};
    tv[7]  = '{ir:T, e_dr:T, default:'0};
    tv[8]  = '{dv:T, drob:3'd6, dop:4'b0010, s1t:3'd5, s2r:T, s2v:32'd9, cv:T, crob:3'd5, cval:32'd7,
               ir:T, e_dr:T, default:'0};
    tv[9]  = '{ir:T, e_dr:T, e_iv:T, e_rob:3'd6, e_op:4'b0010, e_rs1:32'd7, e_rs2:32'd9, default:'0};
    tv[10] = '{ir:T, e_dr:T, default:'0};
    tv[11] = '{head:3'd6, dv:T, drob:3'd1, dop:4'b0001, s1r:T, s1v:32'd11, s2r:T, s2v:32'd12,
               e_dr:T, default:'0};
    tv[12] = '{head:3'd6, dv:T, drob:3'd7, dop:4'b1000, s1r:T, s1v:32'd21, s2r:T, s2v:32'd22,
               e_dr:T, e_iv:T, e_rob:3'd1, e_op:4'b0001, e_rs1:32'd11, e_rs2:32'd12, default:'0};
    tv[13] = '{head:3'd6, ir:T, e_dr:T, e_iv:T, e_rob:3'd7, e_op:4'b1000, e_rs1:32'd21, e_rs2:32'd22,
               default:'0};
    tv[14] = '{head:3'd6, ir:T, e_dr:T, e_iv:T, e_rob:3'd1, e_op:4'b0001, e_rs1:32'd11, e_rs2:32'd12,
               default:'0};
    tv[15] = '{ir:T, e_dr:T, default:'0};

    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_dready", 32'(bus.disp_ready),  32'd1);
    chk("reset_ivalid", 32'(bus.issue_valid), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tv[k]);
      #1;
      chk($sformatf("v%0d_dready", k), 32'(bus.disp_ready),  32'(tv[k].e_dr));
      chk($sformatf("v%0d_ivalid", k), 32'(bus.issue_valid), 32'(tv[k].e_iv));
      if (tv[k].e_iv) begin
        chk($sformatf("v%0d_rob", k), 32'(bus.issue_rob), 32'(tv[k].e_rob));
        chk($sformatf("v%0d_op",  k), 32'(bus.issue_op),  32'(tv[k].e_op));
        chk($sformatf("v%0d_rs1", k), bus.issue_rs1,      tv[k].e_rs1);
        chk($sformatf("v%0d_rs2", k), bus.issue_rs2,      tv[k].e_rs2);
      end
    end

    // Test 5: fill with waiting entries, a fifth dispatch is dropped, one wakeup frees a slot.
    for (int i = 0; i < 4; i++) begin
      nxt();
      disp(3'(i), 4'b0100, 1'b0, 3'(4 + i), 32'd0, 1'b1, 3'd0, 32'(i));
      #1;
      chk($sformatf("fill%0d_dready", i), 32'(bus.disp_ready), 32'd1);
    end
    nxt();
    disp(3'd5, 4'b1000, 1'b1, 3'd0, 32'h5a, 1'b1, 3'd0, 32'h5a);
    #1;
    chk("full_dready",  32'(bus.disp_ready),  32'd0);
    chk("full_ivalid",  32'(bus.issue_valid), 32'd0);
    nxt();
    bus.cdb_valid = 1'b1;
    bus.cdb_rob   = 3'd6;
    bus.cdb_value = 32'h66;
    #1;
    chk("fifth_dropped_iv", 32'(bus.issue_valid), 32'd0);
    chk("fifth_dropped_dr", 32'(bus.disp_ready),  32'd0);
    nxt();
    bus.issue_ready = 1'b1;
    #1;
    chk_issue("wake", 3'd2, 32'h66, 32'd2);
    chk("wake_dready", 32'(bus.disp_ready), 32'd0);
    nxt();
    #1;
    chk("freed_dready", 32'(bus.disp_ready),  32'd1);
    chk("freed_ivalid", 32'(bus.issue_valid), 32'd0);

    // Test 6: flush a full station of ready entries while a dispatch is offered.
    nxt();
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      disp(3'(i), 4'b1000, 1'b1, 3'd0, 32'h100 + 32'(i), 1'b1, 3'd0, 32'h200 + 32'(i));
    end
    nxt();
    #1;
    chk("pref_dready", 32'(bus.disp_ready), 32'd0);
    chk_issue("pref", 3'd0, 32'h100, 32'h200);
    flush = 1'b1;
    disp(3'd4, 4'b1000, 1'b1, 3'd0, 32'h444, 1'b1, 3'd0, 32'h555);
    nxt();
    #1;
    chk("flush_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("flush_dready", 32'(bus.disp_ready),  32'd1);
    nxt();
    #1;
    chk("flush_disp_absent", 32'(bus.issue_valid), 32'd0);

    // Reset in the middle of an issue handshake drops everything.
    nxt();
    disp(3'd3, 4'b0001, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
    nxt();
    #1;
    chk_issue("prerst", 3'd3, 32'd1, 32'd2);
    reset = 1'b1;
    bus.issue_ready = 1'b1;
    disp(3'd5, 4'b0001, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4);
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("rst_dready", 32'(bus.disp_ready),  32'd1);
    nxt();
    #1;
    chk("rst_disp_absent", 32'(bus.issue_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
